param_window_shift_reg: RTL and testbench

//  Parametrised tap shift register for the convolver: holds DEPTH words of WIDTH bits
//  (weights or pixels) and presents all taps in parallel to the MAC array.

---
 rtl/param_window_shift_reg_pkg.sv | 18 +
 rtl/param_window_shift_reg_if.sv | 39 +++
 rtl/param_window_shift_reg_sr_tap_cell.sv | 34 +++
 rtl/param_window_shift_reg.sv | 116 +++++++++++
 tb/tb_param_window_shift_reg.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/param_window_shift_reg_pkg.sv
// Shared types for the convolver tap window: FSM states and per-tap operation select.
package param_window_shift_reg_pkg;
  localparam int WID_FILTER = 16;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } sr_state_e;

  // Operation applied to every tap cell this cycle; clear/reset override in the cell.
  typedef enum logic [1:0] {
    TAP_HOLD  = 2'd0,
    TAP_SHIFT = 2'd1,
    TAP_ROT   = 2'd2,
    TAP_LOAD  = 2'd3
  } tap_op_e;
endpackage

// File: rtl/param_window_shift_reg_if.sv
// Control/data bundle between the fetch path and the tap window.
// SR_PRELOAD_EN adds the parallel preload signals.
interface param_window_shift_reg_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 9
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                   clear;
  logic                   shift_en;
  logic                   rot_en;
  logic [WIDTH-1:0]       inp_sr;
`ifdef SR_PRELOAD_EN
  logic                   preload_en;
  logic [DEPTH*WIDTH-1:0] preload_data;
`endif
  logic [DEPTH*WIDTH-1:0] taps_out;
  logic [CW-1:0]          fill_cnt;
  logic                   full;
  logic [CW-1:0]          rot_cnt;
  logic                   rot_wrap;
  logic                   op_err;

  modport master (
`ifdef SR_PRELOAD_EN
    output preload_en, preload_data,
`endif
    output clear, shift_en, rot_en, inp_sr,
    input  taps_out, fill_cnt, full, rot_cnt, rot_wrap, op_err
  );

  modport slave (
`ifdef SR_PRELOAD_EN
    input  preload_en, preload_data,
`endif
    input  clear, shift_en, rot_en, inp_sr,
    output taps_out, fill_cnt, full, rot_cnt, rot_wrap, op_err
  );
endinterface

// File: rtl/param_window_shift_reg_sr_tap_cell.sv
// One WIDTH-bit tap register with hold/shift/rotate/preload select and sync reset/clear.
module sr_tap_cell
  import param_window_shift_reg_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  tap_op_e          op,
  input  logic [WIDTH-1:0] shift_in,
  input  logic [WIDTH-1:0] rot_in,
  input  logic [WIDTH-1:0] load_in,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    case (op)
      TAP_SHIFT: q_d = shift_in;
      TAP_ROT:   q_d = rot_in;
      TAP_LOAD:  q_d = load_in;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) q_q <= '0;
    else            q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/param_window_shift_reg.sv
// Parallel-tap window for the convolver: DEPTH taps, fill tracking, rotate and clear.
// Optional parallel preload under SR_PRELOAD_EN.
module param_window_shift_reg
  import param_window_shift_reg_pkg::*;
#(
  parameter int WIDTH = WID_FILTER,
  parameter int DEPTH = 9
) (
  input logic                     clk,
  input logic                     rst,
  param_window_shift_reg_if.slave bus
);
  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]  LAST_C  = CW'(DEPTH - 1);

  logic [DEPTH-1:0][WIDTH-1:0] tap_q, ld_vec;
  logic                        pre_req;
  logic                        do_load, do_shift, do_rot;
  tap_op_e                     tap_op;

  sr_state_e     state_d, state_q;
  logic [CW-1:0] fill_cnt_d, fill_cnt_q, rot_cnt_d, rot_cnt_q;
  logic          full_d, full_q, rot_wrap_d, rot_wrap_q, op_err_d, op_err_q;

`ifdef SR_PRELOAD_EN
  assign pre_req = bus.preload_en;
  assign ld_vec  = bus.preload_data;
`else
  assign pre_req = 1'b0;
  assign ld_vec  = '0;
`endif

  always_comb begin
    do_load    = !bus.clear && pre_req;
    do_shift   = !bus.clear && !pre_req && bus.shift_en;
    do_rot     = !bus.clear && !pre_req && !bus.shift_en && bus.rot_en && full_q;
    tap_op     = do_load  ? TAP_LOAD  :
                 do_shift ? TAP_SHIFT :
                 do_rot   ? TAP_ROT   : TAP_HOLD;

    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    rot_cnt_d  = rot_cnt_q;
    rot_wrap_d = 1'b0;
    // A rotate request is illegal when it loses to a shift or the window is not full.
    op_err_d   = !bus.clear && !pre_req && bus.rot_en && (bus.shift_en || !full_q);

    if (bus.clear) begin
      state_d    = ST_EMPTY;
      fill_cnt_d = '0;
      rot_cnt_d  = '0;
      op_err_d   = 1'b0;
    end else if (do_load) begin
      state_d    = ST_FULL;
      fill_cnt_d = DEPTH_C;
      rot_cnt_d  = '0;
    end else if (do_shift) begin
      rot_cnt_d  = '0;
      if (fill_cnt_q < DEPTH_C) fill_cnt_d = fill_cnt_q + 1'b1;
      state_d    = (fill_cnt_d == DEPTH_C) ? ST_FULL : ST_FILLING;
    end else if (do_rot) begin
      rot_wrap_d = (rot_cnt_q == LAST_C);
      rot_cnt_d  = rot_wrap_d ? '0 : rot_cnt_q + 1'b1;
    end

    full_d = (state_d == ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      fill_cnt_q <= '0;
      rot_cnt_q  <= '0;
      full_q     <= 1'b0;
      rot_wrap_q <= 1'b0;
      op_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      rot_cnt_q  <= rot_cnt_d;
      full_q     <= full_d;
      rot_wrap_q <= rot_wrap_d;
      op_err_q   <= op_err_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_tap
    logic [WIDTH-1:0] sh_in, rt_in;
    if (i == 0) begin : g_head
      assign sh_in = bus.inp_sr;
      assign rt_in = tap_q[DEPTH-1];
    end else begin : g_body
      assign sh_in = tap_q[i-1];
      assign rt_in = tap_q[i-1];
    end

    sr_tap_cell #(.WIDTH(WIDTH)) u_cell (
      .clk      (clk),
      .rst      (rst),
      .clr      (bus.clear),
      .op       (tap_op),
      .shift_in (sh_in),
      .rot_in   (rt_in),
      .load_in  (ld_vec[i]),
      .q        (tap_q[i])
    );
  end

  assign bus.taps_out = tap_q;
  assign bus.fill_cnt = fill_cnt_q;
  assign bus.full     = full_q;
  assign bus.rot_cnt  = rot_cnt_q;
  assign bus.rot_wrap = rot_wrap_q;
  assign bus.op_err   = op_err_q;
endmodule

// File: tb/tb_param_window_shift_reg.sv
// Directed + random bench for param_window_shift_reg against a queue-based window model.
module tb_param_window_shift_reg;
  localparam int WIDTH = 16;
  localparam int DEPTH = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_window_shift_reg_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  param_window_shift_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: index 0 is the newest tap.
  logic [WIDTH-1:0]       m_taps[$];
  int                     m_fill, m_rot;
  bit                     m_wrap, m_err;
  logic [DEPTH*WIDTH-1:0] pre_vec;
  logic [DEPTH*WIDTH-1:0] saved;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DEPTH*WIDTH-1:0] m_vec();
    logic [DEPTH*WIDTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i*WIDTH +: WIDTH] = m_taps[i];
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] dtap(input int i);
    return bus.taps_out[i*WIDTH +: WIDTH];
  endfunction

  task automatic model_zero();
    m_taps = {};
    for (int i = 0; i < DEPTH; i++) m_taps.push_back('0);
    m_fill = 0; m_rot = 0; m_wrap = 0; m_err = 0;
  endtask

  task automatic model_step(input bit r, c, p, s, ro, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] t;
    m_wrap = 0; m_err = 0;
    if (r || c) model_zero();
    else if (p) begin
      for (int i = 0; i < DEPTH; i++) m_taps[i] = pre_vec[i*WIDTH +: WIDTH];
      m_fill = DEPTH; m_rot = 0;
    end else if (s) begin
      m_taps.push_front(d);
      t = m_taps.pop_back();
      m_fill = (m_fill < DEPTH) ? m_fill + 1 : DEPTH;
      m_rot = 0;
      m_err = ro;
    end else if (ro) begin
      if (m_fill == DEPTH) begin
        t = m_taps.pop_back();
        m_taps.push_front(t);
        m_rot  = (m_rot + 1) % DEPTH;
        m_wrap = (m_rot == 0);
      end else m_err = 1;
    end
  endtask

  task automatic step(input bit r, c, p, s, ro, input logic [WIDTH-1:0] d);
    rst          = r;
    bus.clear    = c;
    bus.shift_en = s;
    bus.rot_en   = ro;
    bus.inp_sr   = d;
`ifdef SR_PRELOAD_EN
    bus.preload_en   = p;
    bus.preload_data = pre_vec;
`endif
    @(posedge clk);
    #1;
    model_step(r, c, p, s, ro, d);
    chk("taps",     bus.taps_out, m_vec());
    chk("fill_cnt", bus.fill_cnt, m_fill);
    chk("full",     bus.full,     m_fill == DEPTH);
    chk("rot_cnt",  bus.rot_cnt,  m_rot);
    chk("rot_wrap", bus.rot_wrap, m_wrap);
    chk("op_err",   bus.op_err,   m_err);
  endtask

  initial begin
    pre_vec = '0;
    model_zero();
    step(1, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, '0);

    // Fill 1..9, then overflow with 10
    for (int k = 1; k <= DEPTH; k++) step(0, 0, 0, 1, 0, WIDTH'(k));
    chk("fill_tap0", dtap(0), 9);
    chk("fill_tap8", dtap(8), 1);
    chk("fill_full", bus.full, 1);
    step(0, 0, 0, 1, 0, 16'd10);
    chk("ovf_tap8", dtap(8), 2);
    chk("ovf_fill", bus.fill_cnt, 9);

    // Reset with a loaded window
    step(1, 0, 0, 1, 1, 16'h1234);
    chk("rst_tap0", dtap(0), 0);
    chk("rst_full", bus.full, 0);
    step(0, 0, 0, 0, 0, '0);

    // Full rotation cycle
    for (int k = 1; k <= DEPTH; k++) step(0, 0, 0, 1, 0, WIDTH'(k));
    saved = bus.taps_out;
    for (int j = 1; j <= DEPTH; j++) begin
      step(0, 0, 0, 0, 1, '0);
      if (j == 1) chk("rot1_tap0", dtap(0), 1);
      chk("rot_wrap_seq", bus.rot_wrap, j == DEPTH);
    end
    chk("rot_back", bus.taps_out, saved);
    chk("rot_cnt0", bus.rot_cnt, 0);

    // Rotate while not full, then shift+rotate collision
    step(0, 1, 0, 0, 0, '0);
    for (int k = 1; k <= 4; k++) step(0, 0, 0, 1, 0, WIDTH'(16'h100 + k));
    saved = bus.taps_out;
    step(0, 0, 0, 0, 1, '0);
    chk("err_rot_taps", bus.taps_out, saved);
    chk("err_rot_flag", bus.op_err, 1);
    step(0, 0, 0, 0, 0, '0);
    chk("err_pulse", bus.op_err, 0);
    step(0, 0, 0, 1, 1, 16'h0055);
    chk("coll_tap0", dtap(0), 16'h0055);
    chk("coll_err", bus.op_err, 1);
    chk("coll_fill", bus.fill_cnt, 5);

    // Clear beats a simultaneous shift
    step(0, 0, 0, 0, 0, '0);
    step(0, 1, 0, 1, 0, 16'h0077);
    chk("clr_taps", bus.taps_out, 0);
    chk("clr_fill", bus.fill_cnt, 0);
    chk("clr_err", bus.op_err, 0);

`ifdef SR_PRELOAD_EN
    for (int i = 0; i < DEPTH; i++) pre_vec[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
    step(0, 0, 1, 0, 0, '0);
    chk("pre_full", bus.full, 1);
    for (int i = 0; i < DEPTH; i++) chk("pre_tap", dtap(i), i + 1);
    step(0, 0, 0, 1, 0, 16'hAAAA);
    chk("pre_sh_tap0", dtap(0), 16'hAAAA);
    chk("pre_sh_tap8", dtap(8), 16'h0008);
    chk("pre_sh_rot", bus.rot_cnt, 0);
`endif

    // Random mix, biased toward rotates so wraps occur
    for (int n = 0; n < 600; n++) begin
      bit r, c, p, s, ro;
      r  = ($urandom_range(0, 99) < 1);
      c  = ($urandom_range(0, 99) < 4);
`ifdef SR_PRELOAD_EN
      p  = ($urandom_range(0, 99) < 4);
      for (int i = 0; i < DEPTH; i++) pre_vec[i*WIDTH +: WIDTH] = WIDTH'($urandom);
`else
      p  = 1'b0;
`endif
      s  = ($urandom_range(0, 99) < 35);
      ro = ($urandom_range(0, 99) < 60);
      step(r, c, p, s, ro, WIDTH'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
